// File: rtl/onchip_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory.
// Serves one Avalon-MM transaction at a time: writes take 2 cycles, reads 3.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDATA
  } state_e;

  state_e state_q, state_d;
  logic gsel_q, gsel_d;
  logic last_q, last_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic req0, req1;
  logic g_wr, g_rd;
  logic issue, rdat;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Write wins when a requester raises read and write together.
  assign g_wr = gsel_q ? m1_write : m0_write;
  assign g_rd = (gsel_q ? m1_read : m0_read) & ~g_wr;

  // Reset masks the current cycle so an aborted transaction leaves no trace.
  assign issue = (state_q == ISSUE) & ~reset;
  assign rdat  = (state_q == RDATA) & ~reset;

  always_comb begin
    state_d  = state_q;
    gsel_d   = gsel_q;
    last_d   = last_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          gsel_d  = (req0 & req1) ? ~last_q : req1;
          last_d  = gsel_d;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = g_rd ? RDATA : IDLE;
      end
      RDATA: begin
        if (gsel_q) rdata1_d = mem_readdata;
        else        rdata0_d = mem_readdata;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gsel_q   <= 1'b0;
      last_q   <= 1'b1;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      gsel_q   <= gsel_d;
      last_q   <= last_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign m0_waitrequest   = ~(issue & ~gsel_q);
  assign m1_waitrequest   = ~(issue &  gsel_q);
  assign m0_readdatavalid = rdat & ~gsel_q;
  assign m1_readdatavalid = rdat &  gsel_q;
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : rdata0_q;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : rdata1_q;

  assign mem_address    = gsel_q ? m1_address    : m0_address;
  assign mem_byteenable = gsel_q ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = gsel_q ? m1_writedata  : m0_writedata;
  assign mem_chipselect = issue;
  assign mem_write      = issue & g_wr;
  assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: directed scenarios plus randomized
// traffic from both requesters checked against a transaction-level model.
module tb_onchip_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [1:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  logic        tb_clr;
  logic [31:0] bmem [4];
  logic [31:0] ref_mem [4];
  int          n_pass, n_total;

  onchip_mem_arbiter #(.ADDR_W(2), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory slave: registered read, byte-lane writes.
  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 4; i++) bmem[i] <= '0;
      mem_readdata <= '0;
    end else if (mem_chipselect && mem_clken) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b])
            bmem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      mem_readdata <= bmem[mem_address];
    end
  end

  function automatic void ref_write(input logic [1:0] a,
                                    input logic [3:0] be,
                                    input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endfunction

  task automatic set_m(input int m, input logic rd, input logic wr,
                       input logic [1:0] a, input logic [3:0] be,
                       input logic [31:0] d);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a;
      m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a;
      m1_byteenable = be; m1_writedata = d;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Runs one transaction to completion; a missed acceptance counts as a failure.
  task automatic do_txn(input int m, input logic rd, input logic wr,
                        input logic [1:0] a, input logic [3:0] be,
                        input logic [31:0] d,
                        output logic got, output logic [31:0] rdat);
    int n;
    logic wq;
    got = 1'b0;
    rdat = '0;
    @(posedge clk); #1;
    set_m(m, rd, wr, a, be, d);
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      wq = (m == 0) ? m0_waitrequest : m1_waitrequest;
      if (!wq) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    set_m(m, 0, 0, 0, 0, 0);
    if (n >= 20) begin
      n_total++;
      $display("FAIL txn_timeout m%0d: got no accept want accept", m);
    end else if (rd && !wr) begin
      @(negedge clk);
      got  = (m == 0) ? m0_readdatavalid : m1_readdatavalid;
      rdat = (m == 0) ? m0_readdata : m1_readdata;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_total++; if (m0_waitrequest !== 1'b1)
      $display("FAIL rst_m0_wait: got %b want 1", m0_waitrequest); else n_pass++;
    n_total++; if (m1_waitrequest !== 1'b1)
      $display("FAIL rst_m1_wait: got %b want 1", m1_waitrequest); else n_pass++;
    n_total++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00)
      $display("FAIL rst_rdv: got %b%b want 00", m0_readdatavalid, m1_readdatavalid);
    else n_pass++;
    n_total++; if (m0_readdata !== 32'h0 || m1_readdata !== 32'h0)
      $display("FAIL rst_rdata: got %h %h want 0 0", m0_readdata, m1_readdata);
    else n_pass++;
    n_total++; if ({mem_chipselect, mem_write} !== 2'b00)
      $display("FAIL rst_mem: got cs=%b we=%b want 0 0", mem_chipselect, mem_write);
    else n_pass++;
    n_total++; if (mem_clken !== 1'b1)
      $display("FAIL rst_clken: got %b want 1", mem_clken); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    logic [5:0] ew0, ecs, emw, ev0;
    ew0 = 6'b110101; ecs = 6'b001010;
    emw = 6'b000010; ev0 = 6'b010000;
    ref_write(2, 4'hF, 32'hDEADBEEF);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 0) set_m(0, 0, 1, 2, 4'hF, 32'hDEADBEEF);
      if (i == 2) set_m(0, 1, 0, 2, 4'hF, 32'h0);
      if (i == 4) set_m(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_total++; if (m0_waitrequest !== ew0[i])
        $display("FAIL wr_rd_m0_wait c%0d: got %b want %b", i, m0_waitrequest, ew0[i]);
      else n_pass++;
      n_total++; if ({mem_chipselect, mem_write} !== {ecs[i], emw[i]})
        $display("FAIL wr_rd_mem c%0d: got %b%b want %b%b", i,
                 mem_chipselect, mem_write, ecs[i], emw[i]);
      else n_pass++;
      n_total++; if (m0_readdatavalid !== ev0[i])
        $display("FAIL wr_rd_rdv c%0d: got %b want %b", i, m0_readdatavalid, ev0[i]);
      else n_pass++;
      n_total++; if (m1_waitrequest !== 1'b1 || m1_readdatavalid !== 1'b0)
        $display("FAIL wr_rd_m1_quiet c%0d: got %b%b want 10", i,
                 m1_waitrequest, m1_readdatavalid);
      else n_pass++;
      if (ecs[i]) begin
        n_total++; if (mem_address !== 2'd2)
          $display("FAIL wr_rd_addr c%0d: got %0d want 2", i, mem_address);
        else n_pass++;
      end
      if (i >= 4) begin
        n_total++; if (m0_readdata !== 32'hDEADBEEF)
          $display("FAIL wr_rd_data c%0d: got %h want deadbeef", i, m0_readdata);
        else n_pass++;
      end
    end
  endtask

  task automatic test_alternate();
    logic [31:0] d0, d1, a0, a1;
    int g, lastg, grants;
    d0 = 32'h1000_0000; d1 = 32'h2000_0000;
    a0 = '0; a1 = '0; lastg = -1; grants = 0;
    for (int c = 0; c < 40 && grants < 8; c++) begin
      @(posedge clk); #1;
      set_m(0, 0, 1, 0, 4'hF, d0);
      set_m(1, 0, 1, 1, 4'hF, d1);
      @(negedge clk);
      g = -1;
      if (!m0_waitrequest) g = 0;
      if (!m1_waitrequest) g = (g == 0) ? 2 : 1;
      if (g >= 0) begin
        n_total++; if (g == 2 || g == lastg)
          $display("FAIL alt_grant n%0d: got %0d want not %0d", grants, g, lastg);
        else n_pass++;
        if (g == 0) begin a0 = d0; d0 = d0 + 1; end
        if (g == 1) begin a1 = d1; d1 = d1 + 1; end
        lastg = g;
        grants++;
      end
    end
    n_total++; if (grants < 8)
      $display("FAIL alt_timeout: got %0d grants want 8", grants); else n_pass++;
    @(posedge clk); #1;
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    ref_write(0, 4'hF, a0);
    ref_write(1, 4'hF, a1);
    n_total++; if (bmem[0] !== a0)
      $display("FAIL alt_mem0: got %h want %h", bmem[0], a0); else n_pass++;
    n_total++; if (bmem[1] !== a1)
      $display("FAIL alt_mem1: got %h want %h", bmem[1], a1); else n_pass++;
  endtask

  task automatic test_tie();
    logic [5:0] ew0, ew1, ev0, ev1;
    ew0 = 6'b111101; ew1 = 6'b101111;
    ev0 = 6'b000100; ev1 = 6'b100000;
    do_reset();
    set_m(0, 1, 0, 0, 4'hF, 0);
    set_m(1, 1, 0, 1, 4'hF, 0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        if (i == 2) set_m(0, 0, 0, 0, 0, 0);
        if (i == 5) set_m(1, 0, 0, 0, 0, 0);
      end
      @(negedge clk);
      n_total++; if ({m0_waitrequest, m1_waitrequest} !== {ew0[i], ew1[i]})
        $display("FAIL tie_wait c%0d: got %b%b want %b%b", i,
                 m0_waitrequest, m1_waitrequest, ew0[i], ew1[i]);
      else n_pass++;
      n_total++; if ({m0_readdatavalid, m1_readdatavalid} !== {ev0[i], ev1[i]})
        $display("FAIL tie_rdv c%0d: got %b%b want %b%b", i,
                 m0_readdatavalid, m1_readdatavalid, ev0[i], ev1[i]);
      else n_pass++;
      if (i == 2) begin
        n_total++; if (m0_readdata !== ref_mem[0])
          $display("FAIL tie_m0_data: got %h want %h", m0_readdata, ref_mem[0]);
        else n_pass++;
      end
      if (i == 5) begin
        n_total++; if (m1_readdata !== ref_mem[1])
          $display("FAIL tie_m1_data: got %h want %h", m1_readdata, ref_mem[1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_partial();
    logic got;
    logic [31:0] rd;
    do_txn(1, 0, 1, 3, 4'hF, 32'hFFFFFFFF, got, rd);
    ref_write(3, 4'hF, 32'hFFFFFFFF);
    do_txn(1, 0, 1, 3, 4'h3, 32'h0000A5A5, got, rd);
    ref_write(3, 4'h3, 32'h0000A5A5);
    do_txn(1, 1, 0, 3, 4'hF, 32'h0, got, rd);
    n_total++; if (got !== 1'b1)
      $display("FAIL partial_rdv: got %b want 1", got); else n_pass++;
    n_total++; if (rd !== 32'hFFFFA5A5)
      $display("FAIL partial_data: got %h want ffffa5a5", rd); else n_pass++;
  endtask

  task automatic test_reset_rdata();
    logic got;
    logic [31:0] rd;
    int n;
    @(posedge clk); #1;
    set_m(1, 1, 0, 3, 4'hF, 0);
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!m1_waitrequest) break;
      @(posedge clk); #1;
    end
    n_total++; if (n >= 20)
      $display("FAIL rstrd_accept: got no accept want accept"); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    set_m(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_total++; if (m1_readdatavalid !== 1'b0)
      $display("FAIL rstrd_rdv_in_reset: got %b want 0", m1_readdatavalid);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_total++; if (m1_readdatavalid !== 1'b0 || m1_readdata !== 32'h0)
      $display("FAIL rstrd_after: got rdv=%b data=%h want 0 0",
               m1_readdatavalid, m1_readdata);
    else n_pass++;
    n_total++; if ({m0_waitrequest, m1_waitrequest, mem_chipselect} !== 3'b110)
      $display("FAIL rstrd_idle: got %b%b%b want 110",
               m0_waitrequest, m1_waitrequest, mem_chipselect);
    else n_pass++;
    do_txn(0, 1, 0, 3, 4'hF, 0, got, rd);
    n_total++; if (got !== 1'b1 || rd !== ref_mem[3])
      $display("FAIL rstrd_m0_read: got %b %h want 1 %h", got, rd, ref_mem[3]);
    else n_pass++;
  endtask

  task automatic test_rw_both();
    logic got;
    logic [31:0] rd;
    @(posedge clk); #1;
    set_m(0, 1, 1, 0, 4'hF, 32'h12345678);
    @(negedge clk);
    n_total++; if (m0_waitrequest !== 1'b1)
      $display("FAIL rw_c0_wait: got %b want 1", m0_waitrequest); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if ({m0_waitrequest, mem_write} !== 2'b01)
      $display("FAIL rw_c1: got wait=%b we=%b want 0 1", m0_waitrequest, mem_write);
    else n_pass++;
    @(posedge clk); #1;
    set_m(0, 0, 0, 0, 0, 0);
    for (int i = 2; i < 4; i++) begin
      if (i == 3) begin @(posedge clk); #1; end
      @(negedge clk);
      n_total++; if ({m0_readdatavalid, mem_chipselect} !== 2'b00)
        $display("FAIL rw_c%0d: got rdv=%b cs=%b want 0 0", i,
                 m0_readdatavalid, mem_chipselect);
      else n_pass++;
    end
    ref_write(0, 4'hF, 32'h12345678);
    do_txn(0, 1, 0, 0, 4'hF, 0, got, rd);
    n_total++; if (got !== 1'b1 || rd !== 32'h12345678)
      $display("FAIL rw_readback: got %b %h want 1 12345678", got, rd);
    else n_pass++;
  endtask

  // Model: one transaction at a time; the arbiter is free again one cycle
  // after a write acceptance and two after a read acceptance, and takes
  // whoever was pending while free (the one not served last on a tie).
  task automatic test_random();
    logic        act [2], acc [2], pend_prev [2], rd_due [2];
    int          op [2];
    logic [1:0]  ad [2];
    logic [3:0]  be_r [2];
    logic [31:0] dt [2], exp_rd [2], last_rd [2];
    logic        gv, wq, exp_acc;
    logic [31:0] gd;
    int          last_win, win, next_idle;
    for (int m = 0; m < 2; m++) begin
      act[m] = 0; acc[m] = 0; pend_prev[m] = 0; rd_due[m] = 0;
      op[m] = 0; ad[m] = 0; be_r[m] = 0; dt[m] = 0;
      exp_rd[m] = 0; last_rd[m] = 0;
    end
    do_reset();
    last_win = 1;
    next_idle = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        if (acc[m]) begin act[m] = 0; acc[m] = 0; end
        if (!act[m] && cyc < 390 && $urandom_range(0, 2) != 0) begin
          act[m]  = 1;
          op[m]   = $urandom_range(0, 2);
          ad[m]   = 2'($urandom_range(0, 3));
          be_r[m] = 4'($urandom_range(1, 15));
          dt[m]   = $urandom;
        end
        set_m(m, act[m] && op[m] != 1, act[m] && op[m] != 0,
              ad[m], be_r[m], dt[m]);
      end
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        gv = (m == 0) ? m0_readdatavalid : m1_readdatavalid;
        gd = (m == 0) ? m0_readdata : m1_readdata;
        n_total++; if (gv !== rd_due[m])
          $display("FAIL rand_rdv m%0d c%0d: got %b want %b", m, cyc, gv, rd_due[m]);
        else n_pass++;
        n_total++; if (gd !== (rd_due[m] ? exp_rd[m] : last_rd[m]))
          $display("FAIL rand_rdata m%0d c%0d: got %h want %h", m, cyc, gd,
                   rd_due[m] ? exp_rd[m] : last_rd[m]);
        else n_pass++;
        if (rd_due[m]) last_rd[m] = exp_rd[m];
        rd_due[m] = 0;
      end
      exp_acc = (cyc - 1 >= next_idle) && (pend_prev[0] || pend_prev[1]);
      win = (pend_prev[0] && pend_prev[1]) ? 1 - last_win : (pend_prev[1] ? 1 : 0);
      for (int m = 0; m < 2; m++) begin
        wq = (m == 0) ? m0_waitrequest : m1_waitrequest;
        n_total++; if (wq !== !(exp_acc && win == m))
          $display("FAIL rand_wait m%0d c%0d: got %b want %b", m, cyc, wq,
                   !(exp_acc && win == m));
        else n_pass++;
      end
      n_total++; if ({mem_chipselect, mem_write} !== {exp_acc, exp_acc && op[win] != 0})
        $display("FAIL rand_mem c%0d: got %b%b want %b%b", cyc, mem_chipselect,
                 mem_write, exp_acc, exp_acc && op[win] != 0);
      else n_pass++;
      if (exp_acc) begin
        acc[win] = 1;
        last_win = win;
        if (op[win] == 0) begin
          rd_due[win] = 1;
          exp_rd[win] = ref_mem[ad[win]];
          next_idle = cyc + 2;
        end else begin
          ref_write(ad[win], be_r[win], dt[win]);
          next_idle = cyc + 1;
        end
      end
      pend_prev[0] = act[0];
      pend_prev[1] = act[1];
    end
    @(posedge clk); #1;
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    tb_clr = 1'b1;
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1 tb_clr = 1'b0;
    test_reset();
    test_write_read();
    test_alternate();
    test_tie();
    test_partial();
    test_reset_rdata();
    test_rw_both();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timeout");
  end

endmodule
